// File: rtl/vector_ram_loader.sv
// Packs a stream of vector elements lane-wise into RAM words and writes one
// full image of ram_splits words, zero-padding short images.
//
// state  | meaning
// IDLE   | waiting for start; no RAM writes
// FILL   | accepting elements, one RAM word written per filled (or last) word
// PAD    | short image ended; writing zero words up to the image size
// FINISH | final write on the port; done pulses, then back to IDLE
module vector_ram_loader #(
  parameter int val_bits      = 8,
  parameter int ram_width     = 32,
  parameter int ram_splits    = 4,
  parameter int bvb_addr_size = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [bvb_addr_size:0]   image_base,
  input  logic [val_bits-1:0]      in_val,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic                     ram_we,
  output logic [bvb_addr_size:0]   ram_addr,
  output logic [ram_width-1:0]     ram_din,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int lanes  = ram_width / val_bits;
  localparam int lane_w = (lanes > 1) ? $clog2(lanes) : 1;
  localparam int word_w = $clog2(ram_splits + 1);
  localparam int addr_w = bvb_addr_size + 1;

  typedef enum logic [1:0] {IDLE, FILL, PAD, FINISH} state_t;

  state_t              state, state_nxt;
  logic [addr_w-1:0]    base;
  logic [lane_w-1:0]    lane;
  logic [word_w-1:0]    word_idx;
  logic [ram_width-1:0] pack;
  logic [ram_width-1:0] packed_word;
  logic                 accept;
  logic                 word_full;
  logic                 last_word;

  assign accept    = (state == FILL) && in_valid;
  assign word_full = accept && ((lane == lane_w'(lanes - 1)) || in_last);
  assign last_word = (word_idx == word_w'(ram_splits - 1));
  assign busy      = (state != IDLE);

  // Current element merged into its lane; lanes not yet filled stay zero.
  always_comb begin
    packed_word = pack;
    packed_word[lane*val_bits +: val_bits] = in_val;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = FILL;
      end
      FILL: begin
        in_ready = 1'b1;
        if (word_full) begin
          if (in_last)        state_nxt = last_word ? FINISH : PAD;
          else if (last_word) state_nxt = FINISH;
        end
      end
      PAD: begin
        if (last_word) state_nxt = FINISH;
      end
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base     <= '0;
      lane     <= '0;
      word_idx <= '0;
      pack     <= '0;
      err      <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
    end else begin
      ram_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base     <= image_base;
            lane     <= '0;
            word_idx <= '0;
            pack     <= '0;
            err      <= 1'b0;
          end
        end
        FILL: begin
          if (word_full) begin
            ram_we   <= 1'b1;
            ram_addr <= base + addr_w'(word_idx);
            ram_din  <= packed_word;
            pack     <= '0;
            lane     <= '0;
            word_idx <= word_idx + word_w'(1);
            // Image filled without its in_last marker: flag a length error.
            if (!in_last && last_word) err <= 1'b1;
          end else if (accept) begin
            pack <= packed_word;
            lane <= lane + lane_w'(1);
          end
        end
        PAD: begin
          ram_we   <= 1'b1;
          ram_addr <= base + addr_w'(word_idx);
          ram_din  <= '0;
          word_idx <= word_idx + word_w'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_ram_loader.sv
// Self-checking bench for vector_ram_loader: table of images plus hand-written
// reset and corner sequences; RAM writes checked against a scoreboard queue.
module tb_vector_ram_loader;

  localparam int VB = 8;
  localparam int RW = 32;
  localparam int RS = 4;
  localparam int BA = 7;
  localparam int AW = BA + 1;
  localparam int LANES = RW / VB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] image_base = '0;
  logic [VB-1:0] in_val = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [RW-1:0] ram_din;
  logic          busy;
  logic          done;
  logic          err;

  vector_ram_loader #(
    .val_bits(VB), .ram_width(RW), .ram_splits(RS), .bvb_addr_size(BA)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .image_base(image_base),
    .in_val(in_val), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0]         base;
    int                    n;
    logic [VB-1:0]         first;
    bit                    last;
    bit                    gaps;
    int                    glitch;
    bit                    exp_err;
    logic [RS-1:0][RW-1:0] exp_w;
  } vec_t;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [RW-1:0] d;
  } wr_t;

  wr_t  sb_q[$];
  wr_t  mon_e;
  vec_t tbl[7];
  int   n_checks = 0;
  int   n_fail = 0;
  int   img_writes = 0;
  int   done_cnt = 0;
  int   done_base = 0;
  bit   image_done = 1'b0;
  bit   cur_exp_err = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [AW-1:0] base, input int n, input logic [VB-1:0] first,
                              input bit last, input bit gaps, input int glitch, input bit e,
                              input logic [RW-1:0] w0, input logic [RW-1:0] w1,
                              input logic [RW-1:0] w2, input logic [RW-1:0] w3);
    vec_t v;
    v.base = base; v.n = n; v.first = first; v.last = last; v.gaps = gaps;
    v.glitch = glitch; v.exp_err = e;
    v.exp_w[0] = w0; v.exp_w[1] = w1; v.exp_w[2] = w2; v.exp_w[3] = w3;
    return v;
  endfunction

  // Scoreboard consumer: every RAM write is popped and compared.
  always @(negedge clk) begin
    if (rst) begin
      if (ram_we) begin
        chk("we_only_when_busy", busy, 1'b1);
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: addr %0h data %0h, no write expected", ram_addr, ram_din);
        end else begin
          mon_e = sb_q.pop_front();
          chk("ram_addr", ram_addr, mon_e.a);
          chk("ram_din", ram_din, mon_e.d);
        end
        img_writes++;
      end
      if (done) begin
        done_cnt++;
        chk("writes_at_done", img_writes, RS);
        chk("err_at_done", err, cur_exp_err);
        image_done = 1'b1;
      end
    end
  end

  task automatic start_image(input logic [AW-1:0] base, input logic [RS-1:0][RW-1:0] exp_w,
                             input bit exp_err);
    wr_t e;
    @(posedge clk); #1;
    start = 1'b1;
    image_base = base;
    for (int k = 0; k < RS; k++) begin
      e.a = base + AW'(k);
      e.d = exp_w[k];
      sb_q.push_back(e);
    end
    img_writes = 0;
    image_done = 1'b0;
    cur_exp_err = exp_err;
    done_base = done_cnt;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    chk("err_cleared_by_start", err, 1'b0);
    chk("in_ready_in_fill", in_ready, 1'b1);
  endtask

  task automatic send_elem(input logic [VB-1:0] val, input bit last, input bit expect_acc,
                           input bit no_stall, input bit glitch);
    bit acc;
    int budget;
    acc = 1'b0;
    budget = no_stall ? 1 : 8;
    in_val = val;
    in_last = last;
    in_valid = 1'b1;
    if (glitch) begin
      start = 1'b1;
      image_base = 8'h70;
    end
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (acc) break;
    end
    chk(no_stall ? "accept_no_stall" : "accept", acc, expect_acc);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic run_image(input vec_t v);
    int n_acc;
    logic [VB-1:0] val;
    start_image(v.base, v.exp_w, v.exp_err);
    n_acc = v.exp_err ? RS * LANES : v.n;
    for (int i = 0; i < v.n; i++) begin
      if (v.gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      val = v.first + VB'(i);
      send_elem(val, v.last && (i == v.n - 1), i < n_acc, !v.gaps && (i < n_acc), i == v.glitch);
    end
    for (int c = 0; c < 30 && !image_done; c++) begin
      @(negedge clk); #1;
      chk("in_ready_low_after_last", in_ready, 1'b0);
    end
    chk("done_seen", image_done, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    chk("done_pulses", done_cnt - done_base, 1);
    chk("busy_idle", busy, 1'b0);
    chk("err_sticky", err, v.exp_err);
    chk("scoreboard_empty", sb_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = mk(8'h10, 16, 8'h01, 1, 0, -1, 0, 32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D);
    tbl[1] = mk(8'h20,  6, 8'hA0, 1, 0, -1, 0, 32'hA3A2A1A0, 32'h0000A5A4, 32'h00000000, 32'h00000000);
    tbl[2] = mk(8'h30, 17, 8'h01, 0, 0, -1, 1, 32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D);
    tbl[3] = mk(8'hFE, 16, 8'h01, 1, 1, -1, 0, 32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D);
    tbl[4] = mk(8'h7F,  1, 8'h55, 1, 0, -1, 0, 32'h00000055, 32'h00000000, 32'h00000000, 32'h00000000);
    tbl[5] = mk(8'h40,  8, 8'h11, 1, 0, -1, 0, 32'h14131211, 32'h18171615, 32'h00000000, 32'h00000000);
    tbl[6] = mk(8'h60, 12, 8'h21, 1, 0,  3, 0, 32'h24232221, 32'h28272625, 32'h2C2B2A29, 32'h00000000);

    #2 rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_ram_we", ram_we, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_ram_addr", ram_addr, 8'h00);
    chk("rst_ram_din", ram_din, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int t = 0; t < 7; t++) run_image(tbl[t]);

    // Reset in the middle of an image, right while the second write is on the port.
    start_image(8'h50, tbl[0].exp_w, 1'b0);
    for (int i = 0; i < 8; i++) send_elem(VB'(i + 1), 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk); #1;
    chk("writes_before_reset", img_writes, 2);
    chk("we_high_before_reset", ram_we, 1'b1);
    rst = 1'b0;
    #1;
    chk("async_rst_ram_we", ram_we, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_in_ready", in_ready, 1'b0);
    chk("async_rst_ram_din", ram_din, 32'h0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("idle_after_reset", busy, 1'b0);
    run_image(mk(8'h50, 16, 8'h01, 1, 0, -1, 0, 32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_ram_loader.md
Name: vector_ram_loader

Overview:
- Write-side counterpart to the banked vector buffer, which only ever reads vector RAM.
- Accepts a stream of val_bits vector elements and packs them lane-wise into ram_width words.
- Writes one complete image of ram_splits words into vector RAM, starting at a caller-supplied image base address.
- Sits between the host/DMA vector stream and the vector_ram write port. Pulses done when the image is resident.

Parameters:
- val_bits, 8, width of one vector element.
- ram_width, 32, RAM word width in bits; must be a multiple of val_bits. lanes = ram_width/val_bits.
- ram_splits, 4, words per image.
- bvb_addr_size, 7, RAM address width is bvb_addr_size+1.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  begin loading an image; sampled only in IDLE.
- image_base  in  bvb_addr_size+1  first RAM word address of the image; latched on start.
- in_val  in  val_bits  vector element.
- in_valid  in  1  in_val is valid.
- in_last  in  1  marks the final element of the image; qualified by in_valid.
- in_ready  out  1  loader accepts an element this cycle.
- ram_we  out  1  RAM write enable.
- ram_addr  out  bvb_addr_size+1  RAM write address.
- ram_din  out  ram_width  RAM write data.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse when the image is complete.
- err  out  1  sticky length error; cleared by the next accepted start.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; lane, word_idx and pack register cleared; in_ready, ram_we, done, busy, err=0; ram_addr, ram_din=0. A reset mid-image abandons the image, and ram_we drops immediately.
- States: IDLE, FILL, PAD, FINISH.
- IDLE:
  - start=1 → latch base, word_idx=0, lane=0, clear err, go to FILL.
  - start in any other state is ignored.
- FILL:
  - in_ready=1. An element is accepted when in_valid & in_ready.
  - The accepted element goes into lane `lane`, at bits [(lane+1)*val_bits-1 -: val_bits]. Lane 0 is the first element, matching the read-side lane select on local_id.
- Word write (one-cycle registered latency). When the lane = lanes-1 element is accepted, or an in_last element is accepted:
  - Next cycle: ram_we=1, ram_addr=base+word_idx, ram_din=packed word. Unfilled lanes are zero.
  - The pack register clears, lane=0 and word_idx increments in the same edge.
  - in_ready stays high, so back-to-back elements never stall.
- Address arithmetic: modulo 2^(bvb_addr_size+1); wraps silently.
- in_last accepted:
  - If word_idx+1 < ram_splits after that word → PAD.
  - Otherwise → FINISH.
- Word ram_splits-1 completes without in_last: set err, → FINISH. in_ready=0 from the next cycle, so excess elements are not consumed.
- in_last on an element that does not complete word ram_splits-1 (short image) is legal; no err.
- PAD:
  - in_ready=0.
  - Writes zero words one per cycle (ram_we=1, ram_din=0) at base+word_idx until word_idx reaches ram_splits, then → FINISH.
- FINISH:
  - The final ram_we is already issued.
  - done=1 for exactly one cycle, then → IDLE.
  - busy falls with done's deassertion.
- ram_we is never high in IDLE. Exactly ram_splits writes occur per image.

Test Plan:
- Full image: reset, start with image_base=0x10, stream 16 elements 0x01..0x10 with in_last on the 16th. → Writes are addr 0x10=0x04030201, 0x11=0x08070605, 0x12=0x0C0B0A09, 0x13=0x100F0E0D; then done pulses once; err=0.
- Short image: start with base=0x20, send 6 elements 0xA0..0xA5, last on 0xA5. → Writes are 0x20=0xA3A2A1A0, 0x21=0x0000A5A4, 0x22=0, 0x23=0; in_ready=0 during PAD; done after the 4th write.
- Missing in_last: send 17 elements with no in_last. → 4 writes, err=1, and the 17th element is not accepted (in_ready=0). A later start clears err.
- Bubbles and wrap: random in_valid gaps, base=0xFE. → Data is identical to the gap-free case, and addresses are 0xFE, 0xFF, 0x00, 0x01.
- Reset mid-image: assert rst=0 after 2 words are written. → ram_we=0 asynchronously and state=IDLE; no further writes; a new start loads correctly.
- Start while busy: pulse start during FILL with a different base. → Ignored; addresses continue from the original base.
